// File: rtl/ws2812_driver.sv
// rtl/ws2812_driver.sv - WS2812 NRZ serial driver sending one GRB colour to every LED in the chain
module ws2812_driver #(
  parameter int NUM_LEDS     = 8,
  parameter int T0H          = 20,
  parameter int T0L          = 42,
  parameter int T1H          = 40,
  parameter int T1L          = 22,
  parameter int RESET_CYCLES = 3000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  // Terminal counts are the last cycle of each phase, so the timer never wraps.
  localparam logic [15:0] T0H_END   = 16'(T0H - 1);
  localparam logic [15:0] T0L_END   = 16'(T0L - 1);
  localparam logic [15:0] T1H_END   = 16'(T1H - 1);
  localparam logic [15:0] T1L_END   = 16'(T1L - 1);
  localparam logic [15:0] LATCH_END = 16'(RESET_CYCLES - 1);
  localparam logic [7:0]  LAST_LED  = 8'(NUM_LEDS - 1);

  state_t      state, state_nxt;
  logic [23:0] shadow, shadow_nxt;
  logic [4:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  led_cnt, led_cnt_nxt;
  logic [15:0] timer, timer_nxt;
  logic        dout_nxt, busy_nxt, frame_done_nxt;

  logic        cur_bit;
  logic [15:0] high_end, low_end;

  assign cur_bit  = shadow[bit_idx];
  assign high_end = cur_bit ? T1H_END : T0H_END;
  assign low_end  = cur_bit ? T1L_END : T0L_END;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      bit_idx    <= '0;
      led_cnt    <= '0;
      timer      <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shadow     <= shadow_nxt;
      bit_idx    <= bit_idx_nxt;
      led_cnt    <= led_cnt_nxt;
      timer      <= timer_nxt;
      dout       <= dout_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    shadow_nxt     = shadow;
    bit_idx_nxt    = bit_idx;
    led_cnt_nxt    = led_cnt;
    timer_nxt      = timer + 16'd1;
    dout_nxt       = dout;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (enable) begin
          // The colour is latched only here so a frame never mixes colours.
          shadow_nxt  = light;
          bit_idx_nxt = 5'd23;
          led_cnt_nxt = '0;
          dout_nxt    = 1'b1;
          busy_nxt    = 1'b1;
          state_nxt   = HIGH;
        end
      end
      HIGH: begin
        if (timer == high_end) begin
          timer_nxt = '0;
          dout_nxt  = 1'b0;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (timer == low_end) begin
          timer_nxt = '0;
          if (bit_idx != 5'd0) begin
            bit_idx_nxt = bit_idx - 5'd1;
            dout_nxt    = 1'b1;
            state_nxt   = HIGH;
          end else if (led_cnt < LAST_LED) begin
            bit_idx_nxt = 5'd23;
            led_cnt_nxt = led_cnt + 8'd1;
            dout_nxt    = 1'b1;
            state_nxt   = HIGH;
          end else begin
            state_nxt = LATCH;
          end
        end
      end
      LATCH: begin
        if (timer == LATCH_END) begin
          timer_nxt      = '0;
          busy_nxt       = 1'b0;
          frame_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
